// File: rtl/filter_mode_ctrl.sv
// filter_mode_ctrl: debounces four push keys (home/next/prev/lock) and steps
// through NUM_MODES video filter modes. The live mode goes straight to the
// filter datapath. Every new mode is also offered to the LCD text driver over
// a req/ack handshake that keeps the most recent mode if the LCD is slow.
module filter_mode_ctrl #(
  parameter int DELAY_COUNTS   = 2500,
  parameter int NUM_MODES      = 4,
  parameter bit KEY_ACTIVE_LOW = 1'b0,
  localparam int MODE_W = ($clog2(NUM_MODES) > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        key,
  output logic [MODE_W-1:0] filter_type,
  output logic              locked,
  output logic              mode_changed,
  output logic              lcd_req,
  output logic [MODE_W-1:0] lcd_mode,
  input  logic              lcd_ack
);

  localparam int CNT_W = $clog2(DELAY_COUNTS + 1);
  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    REQ,
    RELOAD
  } lcdState_t;

  // Keys are normalised to "1 = pressed" before the synchroniser, so a cleared
  // register always means "released" whatever the board polarity is.
  logic [3:0]       keyNorm;
  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  logic [3:0]       deb_q;
  logic [3:0]       debPrev_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [3:0]       pressEvt;

  logic [MODE_W-1:0] filterType_q;
  logic [MODE_W-1:0] filterType_d;
  logic              locked_q;
  logic              locked_d;
  logic              modeChanged_q;
  logic              modeChange;

  lcdState_t         state_q;
  logic              lcdReq_q;
  logic [MODE_W-1:0] lcdMode_q;
  logic              pending_q;

  assign keyNorm  = KEY_ACTIVE_LOW ? ~key : key;
  assign pressEvt = deb_q & ~debPrev_q;

  // Synchronise each key, then toggle its debounced level only after the
  // synchronised level has disagreed with it for DELAY_COUNTS+1 cycles in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      debPrev_q <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= keyNorm;
      sync2_q   <= sync1_q;
      debPrev_q <= deb_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == CNT_W'(DELAY_COUNTS)) begin
            deb_q[i] <= sync2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // Next mode: the lock toggle is resolved first, and the new lock state gates
  // home > next > prev in that same cycle.
  always_comb begin
    locked_d     = locked_q ^ pressEvt[3];
    filterType_d = filterType_q;
    if (!locked_d) begin
      if (pressEvt[0]) begin
        filterType_d = '0;
      end else if (pressEvt[1]) begin
        filterType_d = (filterType_q == LAST_MODE) ? '0 : filterType_q + 1'b1;
      end else if (pressEvt[2]) begin
        filterType_d = (filterType_q == '0) ? LAST_MODE : filterType_q - 1'b1;
      end
    end
    modeChange = (filterType_d != filterType_q);
  end

  // Mode, lock flag and the change pulse all update on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filterType_q  <= '0;
      locked_q      <= 1'b0;
      modeChanged_q <= 1'b0;
    end else begin
      filterType_q  <= filterType_d;
      locked_q      <= locked_d;
      modeChanged_q <= modeChange;
    end
  end

  // LCD handshake: changes seen during a request are remembered in pending_q,
  // and RELOAD (one cycle with lcd_req low) then sends only the latest mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= INIT;
      lcdReq_q  <= 1'b0;
      lcdMode_q <= '0;
      pending_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          state_q   <= REQ;
          lcdReq_q  <= 1'b1;
          lcdMode_q <= filterType_d;
        end
        IDLE: begin
          if (modeChange) begin
            state_q   <= REQ;
            lcdReq_q  <= 1'b1;
            lcdMode_q <= filterType_d;
          end
        end
        REQ: begin
          if (lcd_ack) begin
            lcdReq_q <= 1'b0;
            if (pending_q || modeChange) begin
              state_q <= RELOAD;
            end else begin
              state_q <= IDLE;
            end
          end else if (modeChange) begin
            pending_q <= 1'b1;
          end
        end
        RELOAD: begin
          state_q   <= REQ;
          lcdReq_q  <= 1'b1;
          lcdMode_q <= filterType_d;
          pending_q <= 1'b0;
        end
        default: begin
          state_q  <= INIT;
          lcdReq_q <= 1'b0;
        end
      endcase
    end
  end

  assign filter_type  = filterType_q;
  assign locked       = locked_q;
  assign mode_changed = modeChanged_q;
  assign lcd_req      = lcdReq_q;
  assign lcd_mode     = lcdMode_q;

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// Testbench for filter_mode_ctrl. A small reference model pushes expected
// filter modes and LCD modes into queues when keys are driven. Monitors pop
// and compare them on every mode_changed pulse and every accepted LCD request.
module tb_filter_mode_ctrl;

  localparam int DELAY     = 2;
  localparam int NUM_MODES = 4;
  localparam int HOLD      = DELAY + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key;
  logic [1:0] filterType;
  logic       locked;
  logic       modeChanged;
  logic       lcdReq;
  logic [1:0] lcdMode;
  logic       lcdAck;

  logic [3:0] key5;
  logic [2:0] filterType5;
  logic       locked5;
  logic       modeChanged5;
  logic       lcdReq5;
  logic [2:0] lcdMode5;
  logic       lcdAck5;

  int checkCount = 0;
  int failCount  = 0;
  int modeQ[$];
  int lcdQ[$];
  int expMode    = 0;
  bit expLocked  = 1'b0;
  bit ackAuto    = 1'b1;
  bit ackForce   = 1'b0;
  bit mcPrev     = 1'b0;

  filter_mode_ctrl #(
    .DELAY_COUNTS  (DELAY),
    .NUM_MODES     (NUM_MODES),
    .KEY_ACTIVE_LOW(1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key         (key),
    .filter_type (filterType),
    .locked      (locked),
    .mode_changed(modeChanged),
    .lcd_req     (lcdReq),
    .lcd_mode    (lcdMode),
    .lcd_ack     (lcdAck)
  );

  filter_mode_ctrl #(
    .DELAY_COUNTS  (DELAY),
    .NUM_MODES     (5),
    .KEY_ACTIVE_LOW(1'b0)
  ) dut5 (
    .clk         (clk),
    .reset       (reset),
    .key         (key5),
    .filter_type (filterType5),
    .locked      (locked5),
    .mode_changed(modeChanged5),
    .lcd_req     (lcdReq5),
    .lcd_mode    (lcdMode5),
    .lcd_ack     (lcdAck5)
  );

  // 100 MHz bench clock.
  always #5 clk = ~clk;

  // LCD driver stand-in: acknowledges one cycle after the request, unless the
  // test takes manual control of the acknowledge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      lcdAck  <= 1'b0;
      lcdAck5 <= 1'b0;
    end else begin
      lcdAck  <= ackAuto ? lcdReq : ackForce;
      lcdAck5 <= lcdReq5;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Monitors sample on the falling edge. Each mode_changed pulse and each
  // accepted LCD request consumes one expected entry from its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (modeChanged) begin
        checkOutput("mc_width", 32'(mcPrev), 32'd0);
        if (modeQ.size() == 0) checkOutput("mc_unexpected", 32'(filterType), 32'hFFFF_FFFF);
        else checkOutput("mode_event", 32'(filterType), 32'(modeQ.pop_front()));
      end
      if (lcdReq && lcdAck) begin
        if (lcdQ.size() == 0) checkOutput("lcd_unexpected", 32'(lcdMode), 32'hFFFF_FFFF);
        else checkOutput("lcd_event", 32'(lcdMode), 32'(lcdQ.pop_front()));
      end
    end
    mcPrev <= modeChanged;
  end

  task automatic applyStimulus(input logic [3:0] k, input int holdCycles);
    @(posedge clk);
    #1;
    key = k;
    repeat (holdCycles) @(posedge clk);
    #1;
    key = 4'b0000;
  endtask

  // Press keys while updating the reference model, then settle and check the
  // steady-state mode and lock flag.
  task automatic pressKeys(input logic [3:0] k, input int holdCycles);
    int newMode;
    if (holdCycles >= HOLD) begin
      if (k[3]) expLocked = !expLocked;
      newMode = expMode;
      if (!expLocked) begin
        if (k[0]) newMode = 0;
        else if (k[1]) newMode = (expMode + 1) % NUM_MODES;
        else if (k[2]) newMode = (expMode + NUM_MODES - 1) % NUM_MODES;
      end
      if (newMode != expMode) begin
        modeQ.push_back(newMode);
        if (ackAuto) lcdQ.push_back(newMode);
        expMode = newMode;
      end
    end
    applyStimulus(k, holdCycles);
    repeat (DELAY + 8) @(posedge clk);
    #1;
    checkOutput("filter_type", 32'(filterType), 32'(expMode));
    checkOutput("locked", 32'(locked), 32'(expLocked));
  endtask

  initial begin
    reset = 1'b1;
    key   = 4'b0000;
    key5  = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_filter", 32'(filterType), 32'd0);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_mc", 32'(modeChanged), 32'd0);
    checkOutput("rst_lcd_req", 32'(lcdReq), 32'd0);
    checkOutput("rst_lcd_mode", 32'(lcdMode), 32'd0);

    lcdQ.push_back(0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("boot_req", 32'(lcdReq), 32'd1);
    checkOutput("boot_mode", 32'(lcdMode), 32'd0);

    expMode = 1;
    modeQ.push_back(1);
    lcdQ.push_back(1);
    applyStimulus(4'b0010, HOLD);
    @(posedge clk);
    #1;
    checkOutput("latency_edge4", 32'(filterType), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("latency_edge5", 32'(filterType), 32'd1);
    repeat (DELAY + 8) @(posedge clk);

    pressKeys(4'b0100, HOLD);
    pressKeys(4'b0100, HOLD);
    pressKeys(4'b0010, HOLD);
    pressKeys(4'b0010, HOLD);
    pressKeys(4'b0010, HOLD);
    pressKeys(4'b0110, HOLD);
    pressKeys(4'b0001, HOLD);
    pressKeys(4'b0001, HOLD);
    pressKeys(4'b0010, 1);
    pressKeys(4'b1000, HOLD);
    pressKeys(4'b0010, HOLD);
    pressKeys(4'b0100, HOLD);
    pressKeys(4'b0001, HOLD);
    pressKeys(4'b1000, HOLD);
    pressKeys(4'b0010, HOLD);
    pressKeys(4'b1010, HOLD);
    pressKeys(4'b1000, HOLD);
    pressKeys(4'b0001, HOLD);

    ackAuto  = 1'b0;
    ackForce = 1'b0;
    lcdQ.push_back(1);
    lcdQ.push_back(3);
    pressKeys(4'b0010, HOLD);
    pressKeys(4'b0010, HOLD);
    pressKeys(4'b0010, HOLD);
    checkOutput("held_req", 32'(lcdReq), 32'd1);
    checkOutput("held_mode", 32'(lcdMode), 32'd1);
    ackForce = 1'b1;
    @(posedge clk);
    #1;
    ackForce = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reload_req_low", 32'(lcdReq), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("reload_req", 32'(lcdReq), 32'd1);
    checkOutput("reload_mode", 32'(lcdMode), 32'd3);
    ackAuto = 1'b1;
    repeat (10) @(posedge clk);

    @(posedge clk);
    #1;
    key5 = 4'b0100;
    repeat (HOLD) @(posedge clk);
    #1;
    key5 = 4'b0000;
    repeat (DELAY + 8) @(posedge clk);
    #1;
    checkOutput("m5_prev_wrap", 32'(filterType5), 32'd4);
    checkOutput("m5_locked", 32'(locked5), 32'd0);

    #1;
    checkOutput("modeQ_empty", 32'(modeQ.size()), 32'd0);
    checkOutput("lcdQ_empty", 32'(lcdQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
